// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmit sequencer.
//                UART register offsets on the MMIO bus and the sequencer
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // UART register offsets
    localparam logic [15:0] c_reg_cr     = 16'h0000;  // control
    localparam logic [15:0] c_reg_sr     = 16'h0001;  // status, bit 1 = TXR
    localparam logic [15:0] c_reg_cdiv_h = 16'h0002;  // clock divider, high byte
    localparam logic [15:0] c_reg_cdiv_l = 16'h0003;  // clock divider, low byte
    localparam logic [15:0] c_reg_di     = 16'h0004;  // receive data
    localparam logic [15:0] c_reg_do     = 16'h0005;  // transmit data

    // Status register bit that reports the transmitter can take a byte
    localparam int c_sr_txr_bit = 1;

    typedef enum logic [3:0] {
        INIT_CDIV_H = 4'd0,
        INIT_CDIV_L = 4'd1,
        INIT_CR     = 4'd2,
        IDLE        = 4'd3,
        POLL_REQ    = 4'd4,
        POLL_CHECK  = 4'd5,
        WRITE_DO    = 4'd6,
        SETTLE      = 4'd7
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with first-word fall-through read port.
//                Push on a full FIFO and pop on an empty FIFO are ignored.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push/push_data  - write request and data
//                pop/pop_data    - read request, pop_data shows the head
//                full/empty      - occupancy flags
//                count           - number of stored entries (0..DEPTH)
//  Parameters  : DEPTH (power of two, >= 2), WIDTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]      c_full = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_full);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sequencer
//  Description : Queues bytes and feeds them to a memory-mapped UART.
//                After reset it programs the clock divider and control
//                register, then for every queued byte polls the status
//                register until TXR is set, writes the byte to DO and waits
//                SETTLE_CYCLES before the next poll.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                wr_valid/wr_data/wr_ready - byte push handshake
//                device_select, mmio_addr, mmio_wdata, mmio_wr, mmio_rd
//                                          - MMIO master request
//                mmio_rdata               - read data, valid cycle after mmio_rd
//                busy, err, fifo_count    - status
//  Option      : UART_SEQ_TIMEOUT_EN - abort a byte after TIMEOUT_POLLS
//                consecutive not-ready polls and raise sticky err.
//                Undefined: polling never gives up and err is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sequencer #(
    parameter logic [2:0]  DEVICE_ADDRESS = 3'b011,
    parameter logic [15:0] CDIV           = 16'd87,
    parameter logic [7:0]  CR_INIT        = 8'h01,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          SETTLE_CYCLES  = 4,
    parameter int          TIMEOUT_POLLS  = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic [2:0]                    device_select,
    output logic [15:0]                   mmio_addr,
    output logic [7:0]                    mmio_wdata,
    output logic                          mmio_wr,
    output logic                          mmio_rd,
    input  logic [7:0]                    mmio_rdata,
    output logic                          busy,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    import uart_pkg::*;

    // SETTLE counts 0..SETTLE_CYCLES-1
    localparam int                      c_settle_w    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_settle_w-1:0]   c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);

    uart_state_t       r_state;
    uart_state_t       w_next_state;
    logic [c_settle_w-1:0] r_settle_cnt;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [7:0]        w_fifo_head;
    logic              w_push;
    logic              w_pop;
    logic              w_wr;
    logic              w_rd;
    logic [15:0]       w_addr;
    logic [7:0]        w_wdata;
    logic              w_txr;
    logic              w_timeout;

    assign w_txr    = mmio_rdata[c_sr_txr_bit];
    assign wr_ready = !w_fifo_full;
    assign w_push   = wr_valid && wr_ready;

    // Only TXR is of interest in the status byte
    logic w_unused_rdata;
    assign w_unused_rdata = ^{mmio_rdata[7:2], mmio_rdata[0]};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

`ifdef UART_SEQ_TIMEOUT_EN
    // Poll counter holds the number of not-ready samples seen so far
    localparam int                    c_poll_w    = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;
    localparam logic [c_poll_w-1:0]   c_poll_last = c_poll_w'(TIMEOUT_POLLS - 1);

    logic [c_poll_w-1:0] r_poll_cnt;
    logic                r_err;

    assign w_timeout = (r_state == POLL_CHECK) && !w_txr && (r_poll_cnt == c_poll_last);
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_poll_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == POLL_CHECK) begin
                if (w_txr || w_timeout) r_poll_cnt <= '0;
                else                    r_poll_cnt <= r_poll_cnt + 1'b1;
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    localparam int c_unused_timeout_polls = TIMEOUT_POLLS;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT_CDIV_H;
            r_settle_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == SETTLE) r_settle_cnt <= r_settle_cnt + 1'b1;
            else                   r_settle_cnt <= '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        w_addr       = 16'h0000;
        w_wdata      = 8'h00;
        w_pop        = 1'b0;
        case (r_state)
            INIT_CDIV_H: begin
                w_wr         = 1'b1;
                w_addr       = c_reg_cdiv_h;
                w_wdata      = CDIV[15:8];
                w_next_state = INIT_CDIV_L;
            end
            INIT_CDIV_L: begin
                w_wr         = 1'b1;
                w_addr       = c_reg_cdiv_l;
                w_wdata      = CDIV[7:0];
                w_next_state = INIT_CR;
            end
            INIT_CR: begin
                w_wr         = 1'b1;
                w_addr       = c_reg_cr;
                w_wdata      = CR_INIT;
                w_next_state = IDLE;
            end
            IDLE: begin
                if (!w_fifo_empty) w_next_state = POLL_REQ;
            end
            POLL_REQ: begin
                w_rd         = 1'b1;
                w_addr       = c_reg_sr;
                w_next_state = POLL_CHECK;
            end
            POLL_CHECK: begin
                if (w_txr) begin
                    w_next_state = WRITE_DO;
                end else if (w_timeout) begin
                    // Give up on this byte: drop it and go look at the queue again
                    w_pop        = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = POLL_REQ;
                end
            end
            WRITE_DO: begin
                w_wr         = 1'b1;
                w_addr       = c_reg_do;
                w_wdata      = w_fifo_head;
                w_pop        = 1'b1;
                w_next_state = SETTLE;
            end
            SETTLE: begin
                if (r_settle_cnt == c_settle_last) w_next_state = IDLE;
            end
            default: w_next_state = INIT_CDIV_H;
        endcase
    end

    // The state register already sits in INIT_CDIV_H while rst is high; the
    // bus request is masked so no access leaks out until rst is released.
    assign mmio_wr       = w_wr && !rst;
    assign mmio_rd       = w_rd && !rst;
    assign mmio_addr     = rst ? 16'h0000 : w_addr;
    assign mmio_wdata    = rst ? 8'h00 : w_wdata;
    assign device_select = DEVICE_ADDRESS;
    assign busy          = (r_state != IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire
